// File: rtl/ssd_msg_scheduler.sv
// ssd_msg_scheduler: round-robin arbiter of dwell-timed display messages onto the SSD word select.
// Optional SSD_SCHED_PREEMPT_EN gives requester 0 preemptive and selection priority.
module ssd_msg_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DWELL_CYCLES = 100000000,
  parameter int CNT_W = 27,
  parameter logic [2:0] IDLE_CODE = 3'd6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   req_code,
  output logic [NUM_REQ-1:0]     grant,
  output logic [2:0]             to_display,
  output logic                   busy
);
  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic S_IDLE = 1'b0;
  localparam logic S_SHOW = 1'b1;
  logic                 state_q, state_d;
  logic [NUM_REQ-1:0]   pend_q, pend_d, grant_q, grant_d;
  logic [3*NUM_REQ-1:0] code_q, code_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LW-1:0]        last_q, last_d, win, idx;
  logic [2:0]           disp_q, disp_d;
  logic                 found, term, go, preempt;
`ifdef SSD_SCHED_PREEMPT_EN
  logic [LW-1:0]        cur_q, cur_d;
`endif
  always_comb begin
    win = last_q;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = LW'((32'(last_q) + k) % NUM_REQ);
      if (!found && pend_q[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
`ifdef SSD_SCHED_PREEMPT_EN
    if (pend_q[0]) win = '0;
    preempt = state_q == S_SHOW && pend_q[0] && cur_q != '0;
    cur_d = cur_q;
`else
    preempt = 1'b0;
`endif
    term = cnt_q == CNT_W'(DWELL_CYCLES - 1);
    go = |pend_q && (state_q == S_IDLE || term || preempt);
    state_d = state_q;
    pend_d = pend_q;
    code_d = code_q;
    cnt_d = cnt_q;
    last_d = last_q;
    grant_d = '0;
    disp_d = disp_q;
    if (go) begin
      state_d = S_SHOW;
      cnt_d = '0;
      pend_d[win] = 1'b0;
      grant_d[win] = 1'b1;
      disp_d = code_q[3*win +: 3];
      last_d = win;
`ifdef SSD_SCHED_PREEMPT_EN
      cur_d = win;
`endif
    end else if (state_q == S_SHOW) begin
      state_d = term ? S_IDLE : S_SHOW;
      cnt_d = term ? '0 : cnt_q + CNT_W'(1);
      disp_d = term ? IDLE_CODE : disp_q;
    end
    // Requests apply after the grant clear so a same-cycle re-request stays pending.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        pend_d[i] = req_code[3*i +: 3] != 3'd7;
        code_d[3*i +: 3] = (req_code[3*i +: 3] != 3'd7) ? req_code[3*i +: 3] : code_q[3*i +: 3];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pend_q <= '0;
      code_q <= '0;
      cnt_q <= '0;
      last_q <= LW'(NUM_REQ - 1);
      grant_q <= '0;
      disp_q <= IDLE_CODE;
`ifdef SSD_SCHED_PREEMPT_EN
      cur_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      code_q <= code_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      grant_q <= grant_d;
      disp_q <= disp_d;
`ifdef SSD_SCHED_PREEMPT_EN
      cur_q <= cur_d;
`endif
    end
  end
  assign grant = grant_q;
  assign to_display = disp_q;
  assign busy = state_q;
endmodule
